// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: ALU function codes, jXX/cmovXX condition codes and the CC layout.
package y86_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;

  localparam logic [3:0] C_ALWAYS = 4'd0;
  localparam logic [3:0] C_LE     = 4'd1;
  localparam logic [3:0] C_L      = 4'd2;
  localparam logic [3:0] C_E      = 4'd3;
  localparam logic [3:0] C_NE     = 4'd4;
  localparam logic [3:0] C_GE     = 4'd5;
  localparam logic [3:0] C_G      = 4'd6;

  // Packed so that a cc_t reads as {ZF,SF,OF}.
  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

endpackage

// File: rtl/cc_cond_unit_if.sv
// ALU result/overflow bus from the Execute-stage ALU to the condition-code unit.
interface cc_cond_unit_if #(
  parameter int unsigned WIDTH = 64
) ();

  logic             alu_valid;
  logic [WIDTH-1:0] alu_result;
  logic             alu_overflow;
  logic [3:0]       alu_fun;
  logic             set_cc;

  modport master (
    output alu_valid,
    output alu_result,
    output alu_overflow,
    output alu_fun,
    output set_cc
  );

  modport slave (
    input alu_valid,
    input alu_result,
    input alu_overflow,
    input alu_fun,
    input set_cc
  );

endinterface

// File: rtl/cond_eval.sv
// Combinational Y86-64 jXX/cmovXX condition evaluation against a set of flags.
module cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] ifun,
  input  cc_t        cc,
  output logic       cond
);

  logic lt;

  always_comb begin
    lt   = cc.sf ^ cc.of;
    cond = 1'b0;
    case (ifun)
      C_ALWAYS: cond = 1'b1;
      C_LE:     cond = lt | cc.zf;
      C_L:      cond = lt;
      C_E:      cond = cc.zf;
      C_NE:     cond = ~cc.zf;
      C_GE:     cond = ~lt;
      C_G:      cond = ~lt & ~cc.zf;
      default:  cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/cc_cond_unit.sv
// Condition-code register and branch/cmov condition evaluation for the Execute stage.
// Define CC_BYPASS_EN to forward the flags being written this cycle into cond.
module cc_cond_unit
  import y86_pkg::*;
#(
  parameter int unsigned WIDTH    = 64,
  parameter logic [2:0]  CC_RESET = 3'b100
) (
  input  logic                 clk,
  input  logic                 rst,
  cc_cond_unit_if.slave        alu,
  input  logic                 exc_pending,
  input  logic                 stall,
  input  logic [3:0]           ifun,
  output logic [2:0]           cc_out,
  output logic                 cond,
  output logic                 cc_updated
);

  cc_t  cc_q, cc_d, cc_new, cc_eval;
  logic cc_updated_q, cc_updated_d;
  logic fun_ok, we;

  always_comb begin
    fun_ok    = (alu.alu_fun <= ALU_XOR);
    we        = alu.alu_valid & alu.set_cc & ~exc_pending & ~stall & fun_ok;
    cc_new.zf = (alu.alu_result == '0);
    cc_new.sf = alu.alu_result[WIDTH-1];
    // Logical ops cannot overflow; the ALU's overflow line is meaningless for them.
    cc_new.of = ((alu.alu_fun == ALU_ADD) || (alu.alu_fun == ALU_SUB)) ? alu.alu_overflow : 1'b0;

    cc_d         = cc_q;
    cc_updated_d = 1'b0;
    if (we) begin
      cc_d         = cc_new;
      cc_updated_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_q         <= cc_t'(CC_RESET);
      cc_updated_q <= 1'b0;
    end else begin
      cc_q         <= cc_d;
      cc_updated_q <= cc_updated_d;
    end
  end

`ifdef CC_BYPASS_EN
  assign cc_eval = we ? cc_new : cc_q;
`else
  assign cc_eval = cc_q;
`endif

  cond_eval u_cond_eval (
    .ifun (ifun),
    .cc   (cc_eval),
    .cond (cond)
  );

  assign cc_out     = cc_q;
  assign cc_updated = cc_updated_q;

endmodule

// File: tb/tb_cc_cond_unit.sv
// Directed self-checking bench for cc_cond_unit.
module tb_cc_cond_unit;

  logic       clk;
  logic       rst;
  logic       exc_pending;
  logic       stall;
  logic [3:0] ifun;
  logic [2:0] cc_out;
  logic       cond;
  logic       cc_updated;

  int n_vec;
  int n_err;

  cc_cond_unit_if #(.WIDTH(64)) alu_if ();

  cc_cond_unit #(
    .WIDTH    (64),
    .CC_RESET (3'b100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alu         (alu_if),
    .exc_pending (exc_pending),
    .stall       (stall),
    .ifun        (ifun),
    .cc_out      (cc_out),
    .cond        (cond),
    .cc_updated  (cc_updated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic sc, input logic [3:0] fn,
                       input logic [63:0] res, input logic ovf);
    alu_if.alu_valid    = v;
    alu_if.set_cc       = sc;
    alu_if.alu_fun      = fn;
    alu_if.alu_result   = res;
    alu_if.alu_overflow = ovf;
  endtask

  task automatic cond_chk(input string tag, input logic [3:0] f, input logic exp);
    ifun = f;
    #1;
    check(tag, {7'd0, cond}, {7'd0, exp});
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b1;
    exc_pending = 1'b0;
    stall       = 1'b0;
    ifun        = 4'd0;
    drive(1'b0, 1'b0, 4'd0, 64'd0, 1'b0);

    // 1: reset state
    tick();
    rst = 1'b0;
    check("rst_cc", {5'd0, cc_out}, 8'h04);
    check("rst_upd", {7'd0, cc_updated}, 8'h00);
    cond_chk("rst_e", 4'd3, 1'b1);
    cond_chk("rst_l", 4'd2, 1'b0);

    // 2: sub giving zero
    drive(1'b1, 1'b1, 4'd1, 64'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 64'd0, 1'b0);
    check("sub0_cc", {5'd0, cc_out}, 8'h04);
    check("sub0_upd", {7'd0, cc_updated}, 8'h01);
    cond_chk("sub0_le", 4'd1, 1'b1);

    // 3: add, MSB-only result with overflow
    drive(1'b1, 1'b1, 4'd0, 64'h8000_0000_0000_0000, 1'b1);
    tick();
    drive(1'b0, 1'b0, 4'd0, 64'd0, 1'b0);
    check("addmin_cc", {5'd0, cc_out}, 8'h03);
    cond_chk("addmin_ge", 4'd5, 1'b1);
    cond_chk("addmin_l", 4'd2, 1'b0);

    // 4: xor, OF forced low
    drive(1'b1, 1'b1, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    tick();
    drive(1'b0, 1'b0, 4'd0, 64'd0, 1'b0);
    check("xor_cc", {5'd0, cc_out}, 8'h02);
    cond_chk("xor_l", 4'd2, 1'b1);
    cond_chk("xor_g", 4'd6, 1'b0);
    cond_chk("xor_ne", 4'd4, 1'b1);
    cond_chk("xor_always", 4'd0, 1'b1);
    cond_chk("xor_f7", 4'd7, 1'b0);
    cond_chk("xor_f15", 4'd15, 1'b0);
    tick();
    check("idle_upd", {7'd0, cc_updated}, 8'h00);

    // 5: blocked updates
    stall = 1'b1;
    drive(1'b1, 1'b1, 4'd1, 64'd0, 1'b0);
    tick();
    stall = 1'b0;
    check("stall_cc", {5'd0, cc_out}, 8'h02);
    check("stall_upd", {7'd0, cc_updated}, 8'h00);
    exc_pending = 1'b1;
    tick();
    exc_pending = 1'b0;
    check("exc_cc", {5'd0, cc_out}, 8'h02);
    check("exc_upd", {7'd0, cc_updated}, 8'h00);
    drive(1'b1, 1'b1, 4'd4, 64'd0, 1'b0);
    tick();
    check("badfun_cc", {5'd0, cc_out}, 8'h02);
    check("badfun_upd", {7'd0, cc_updated}, 8'h00);
    drive(1'b1, 1'b0, 4'd1, 64'd0, 1'b0);
    tick();
    check("nosetcc_cc", {5'd0, cc_out}, 8'h02);
    drive(1'b1, 1'b1, 4'd1, 64'd0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 64'd0, 1'b0);
    check("rstwe_cc", {5'd0, cc_out}, 8'h04);
    check("rstwe_upd", {7'd0, cc_updated}, 8'h00);

    // 6: same-cycle forwarding into cond
    drive(1'b1, 1'b1, 4'd1, 64'd5, 1'b0);
    ifun = 4'd4;
    #1;
`ifdef CC_BYPASS_EN
    check("byp_ne", {7'd0, cond}, 8'h01);
`else
    check("byp_ne", {7'd0, cond}, 8'h00);
`endif
    check("byp_cc_reg", {5'd0, cc_out}, 8'h04);
    tick();
    drive(1'b0, 1'b0, 4'd0, 64'd0, 1'b0);
    check("pos_cc", {5'd0, cc_out}, 8'h00);
    cond_chk("pos_g", 4'd6, 1'b1);
    cond_chk("pos_ne", 4'd4, 1'b1);

    // min+min wraps to zero with overflow
    drive(1'b1, 1'b1, 4'd0, 64'd0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 4'd0, 64'd0, 1'b0);
    check("minmin_cc", {5'd0, cc_out}, 8'h05);
    cond_chk("minmin_le", 4'd1, 1'b1);
    cond_chk("minmin_g", 4'd6, 1'b0);
    cond_chk("minmin_ge", 4'd5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
